filter_test_sequencer: RTL and testbench
========================================

# filter_test_sequencer

Sweep controller for the exponential-signal generator and the filter bank in the filter top level. On a start pulse it drives the generator's overlay, rate and delay controls through a programmed delay sweep, optionally repeating each delay with overlay on. For each step it settles, then records the peak of one selected filter output over a dwell window and reports it. It replaces the static `test_*` pins at the top level, so filter comparisons run unattended.

## Interface
- `SETTLE_CYCLES`, 16: cycles ignored after each control change; must be ≥ 2.
- `DWELL_CYCLES`, 1024: measurement cycles per step; must be ≥ 1.
- `DELAY_FIRST`, 0: first delay value.
- `DELAY_LAST`, 31: last delay value; must be ≥ `DELAY_FIRST`.
- `DELAY_INCR`, 1: delay increment; must be ≥ 1.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse; begins a sweep when idle.
- `abort`  in  1  ends the sweep; takes priority over `start`.
- `cfg_rate`  in  1  rate setting; latched at start.
- `cfg_overlay_en`  in  1  if 1, each delay runs twice (overlay 0, then 1); latched at start.
- `cfg_sel`  in  3  monitored filter: 0..5 selects v1..v6, 6/7 selects v1; latched at start.
- `filter_data`  in  6*SIZE_FILTER_DATA  packed filter outputs, v1 in the LSBs, signed two's complement.
- `test_overlay`  out  1  to the generator.
- `test_rate`  out  1  to the generator.
- `test_delay`  out  SIZE_DELAY  to the generator.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse on the final report.
- `result_valid`  out  1  one-cycle pulse per step.
- `result_peak`  out  SIZE_FILTER_DATA  signed peak for the step.
- `result_delay`  out  SIZE_DELAY  delay for the step.
- `result_overlay`  out  1  overlay for the step.

## Operation
- States: IDLE, SETTLE, MEASURE, REPORT.
- IDLE: when `start` is high and `abort` is low, latch the cfg inputs, set delay to `DELAY_FIRST` and overlay to 0, then go to SETTLE.
- SETTLE: counts `SETTLE_CYCLES` cycles, then goes to MEASURE. On entry to MEASURE, the peak register loads the most-negative value.
- MEASURE: runs `DWELL_CYCLES` cycles. Each cycle, peak = signed max(peak, sample register). Then go to REPORT.
- REPORT: one cycle. `result_valid` is high, and the `result_*` fields hold the peak, delay and overlay for the step. Next step:
  - if `cfg_overlay_en` is set and overlay is 0, set overlay to 1 and go to SETTLE;
  - otherwise, if delay + `DELAY_INCR` > `DELAY_LAST`, pulse `done` in this same cycle and go to IDLE;
  - otherwise, add `DELAY_INCR` to delay, clear overlay and go to SETTLE.
- Sample register: takes the selected slice of `filter_data` every cycle, so there is one cycle of input latency.
- Width rule: the termination compare is done in SIZE_DELAY+1 bits, so the delay never wraps.
- `test_rate` = latched rate while busy. In IDLE, `test_overlay`, `test_rate` and `test_delay` are 0.
- `result_*` hold their last values until the next REPORT.
- `abort` in any non-IDLE state: IDLE on the next edge. No `result_valid` and no `done` are produced, and the test outputs return to 0.
- `start` while busy is ignored. So is `start` in the same cycle as `done`, because `busy` is still high.
- Reset: state IDLE, every output 0.

## Timing
- `start` sampled at edge 0 gives `busy` = 1 and updated test outputs from cycle 1.
- Each step takes `SETTLE_CYCLES` + `DWELL_CYCLES` + 1 cycles.
- Steps N = ((`DELAY_LAST` − `DELAY_FIRST`)/`DELAY_INCR` + 1) × (`cfg_overlay_en` ? 2 : 1).
- k-th report (k = 1..N) falls in cycle k·(S+D+1), where S = `SETTLE_CYCLES` and D = `DWELL_CYCLES`.
- `done` coincides with the N-th report. `busy` falls the following cycle.
- The peak covers `filter_data` presented during cycles (step start + S − 1) through (step start + S + D − 2).

## Structure
- Add to `package_settings`: `NUM_FILTERS` = 6, `SIZE_FILTER_SEL` = 3, and the enum typedef `seq_state_t` (IDLE, SETTLE, MEASURE, REPORT).
- The existing `SIZE_DELAY` and `SIZE_FILTER_DATA` come from the same package.
- One sub-module, `peak_detector`: inputs clear, enable and data; output peak; signed max.
- The top level instantiates this block, which drives the `ExpSigGen` controls.

## Test plan
All scenarios use S=4, D=8, FIRST=2, LAST=6, INCR=2.
- Reset held 3 cycles → all outputs 0, `busy` = 0; they stay 0 with no `start`.
- `start` at cycle 0, overlay_en=0 → `test_delay` 2/4/6; `result_valid` at cycles 13, 26, 39; `done` at 39; `busy` low at 40.
- overlay_en=1 → six reports at (2,0), (2,1), (4,0), (4,1), (6,0), (6,1); `done` at cycle 78.
- sel=3, v4 held at −5 with one +100 in the dwell and +500 during settle → `result_peak` = 100. With v4 all −7 → peak −7. With sel=7, the peak tracks v1.
- `abort` at cycle 20 (step 2 MEASURE) → cycle 21: `busy` = 0, test outputs 0, no `done`. `start` together with `abort` in IDLE → stays idle.
- `start` re-pulsed at cycles 5 and 39 → ignored; the sweep timing is unchanged.

Source files
------------

// File: rtl/filter_test_sequencer_pkg.sv
// Shared settings for the filter top level and its test sequencer.
//   SIZE_DELAY       : width of the generator delay control
//   SIZE_FILTER_DATA : width of one signed filter output
//   NUM_FILTERS      : number of filter outputs packed on filter_data
//   SIZE_FILTER_SEL  : width of the monitored-filter select
//   seq_state_t      : sweep controller states
package filter_test_sequencer_pkg;

    localparam int unsigned SIZE_DELAY       = 5;
    localparam int unsigned SIZE_FILTER_DATA = 16;
    localparam int unsigned NUM_FILTERS      = 6;
    localparam int unsigned SIZE_FILTER_SEL  = 3;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        MEASURE,
        REPORT
    } seq_state_t;

endpackage

// File: rtl/filter_test_sequencer_if.sv
// Control/result bundle of the filter test sequencer.
//   master : issues start/abort with the sweep configuration, observes results
//   slave  : the sequencer; reports busy/done and one result per step
interface filter_test_sequencer_if;
    import filter_test_sequencer_pkg::*;

    logic                               start;
    logic                               abort;
    logic                               cfg_rate;
    logic                               cfg_overlay_en;
    logic [SIZE_FILTER_SEL-1:0]         cfg_sel;
    logic                               busy;
    logic                               done;
    logic                               result_valid;
    logic signed [SIZE_FILTER_DATA-1:0] result_peak;
    logic [SIZE_DELAY-1:0]              result_delay;
    logic                               result_overlay;

    modport master (
        output start, abort, cfg_rate, cfg_overlay_en, cfg_sel,
        input  busy, done, result_valid, result_peak, result_delay, result_overlay
    );

    modport slave (
        input  start, abort, cfg_rate, cfg_overlay_en, cfg_sel,
        output busy, done, result_valid, result_peak, result_delay, result_overlay
    );

endinterface

// File: rtl/filter_test_sequencer_peak_detector.sv
// Running signed maximum of a sample stream.
//   clk, reset : clock and synchronous active-high reset (peak returns to 0)
//   clear      : load the most-negative value (wins over enable)
//   enable     : fold data into the running maximum this cycle
//   data       : signed sample
//   peak       : current signed maximum
module filter_test_sequencer_peak_detector
    import filter_test_sequencer_pkg::*;
(
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               clear,
    input  logic                               enable,
    input  logic signed [SIZE_FILTER_DATA-1:0] data,
    output logic signed [SIZE_FILTER_DATA-1:0] peak
);

    localparam logic signed [SIZE_FILTER_DATA-1:0] MOST_NEG =
        {1'b1, {(SIZE_FILTER_DATA-1){1'b0}}};

    logic signed [SIZE_FILTER_DATA-1:0] peak_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            peak_q <= '0;
        end else if (clear) begin
            peak_q <= MOST_NEG;
        end else if (enable && (data > peak_q)) begin
            peak_q <= data;
        end
    end

    assign peak = peak_q;

endmodule

// File: rtl/filter_test_sequencer.sv
// Sweep controller for the exponential-signal generator and the filter bank.
// A start pulse walks test_delay from DELAY_FIRST to DELAY_LAST in DELAY_INCR
// steps (each delay optionally repeated with overlay set). Every step settles,
// measures the peak of the selected filter output, then reports it for one cycle.
//   clk, reset   : clock and synchronous active-high reset
//   bus          : start/abort/cfg in, busy/done/result_* out
//   filter_data  : six packed signed filter outputs, v1 in the LSBs
//   test_overlay, test_rate, test_delay : generator controls, 0 while idle
module filter_test_sequencer
    import filter_test_sequencer_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned DWELL_CYCLES  = 1024,
    parameter int unsigned DELAY_FIRST   = 0,
    parameter int unsigned DELAY_LAST    = 31,
    parameter int unsigned DELAY_INCR    = 1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    filter_test_sequencer_if.slave                  bus,
    input  logic [NUM_FILTERS*SIZE_FILTER_DATA-1:0] filter_data,
    output logic                                    test_overlay,
    output logic                                    test_rate,
    output logic [SIZE_DELAY-1:0]                   test_delay
);

    // Delay arithmetic is one bit wider so the last increment cannot wrap.
    localparam int unsigned     DW1    = SIZE_DELAY + 1;
    localparam logic [DW1-1:0]  INCR_W = DW1'(DELAY_INCR);
    localparam logic [DW1-1:0]  LAST_W = DW1'(DELAY_LAST);

    seq_state_t                         state_q, state_d;
    logic [31:0]                        cnt_q, cnt_d;
    logic [SIZE_DELAY-1:0]              delay_q, delay_d;
    logic                               overlay_q, overlay_d;
    logic                               rate_q, rate_d;
    logic                               ov_en_q, ov_en_d;
    logic [SIZE_FILTER_SEL-1:0]         sel_q, sel_d;
    logic signed [SIZE_FILTER_DATA-1:0] sample_q, sample_d;
    logic signed [SIZE_FILTER_DATA-1:0] res_peak_q;
    logic [SIZE_DELAY-1:0]              res_delay_q;
    logic                               res_overlay_q;
    logic signed [SIZE_FILTER_DATA-1:0] peak;
    logic                               peak_clear;
    logic                               peak_en;
    logic                               report;
    logic                               last_step;
    logic [DW1-1:0]                     delay_next;
    logic                               busy;

    // Selects 6 and 7 fall through to v1.
    always_comb begin
        sample_d = filter_data[SIZE_FILTER_DATA-1:0];
        for (int i = 1; i < NUM_FILTERS; i++) begin
            if (sel_q == SIZE_FILTER_SEL'(i)) begin
                sample_d = filter_data[i*SIZE_FILTER_DATA +: SIZE_FILTER_DATA];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        delay_d    = delay_q;
        overlay_d  = overlay_q;
        rate_d     = rate_q;
        ov_en_d    = ov_en_q;
        sel_d      = sel_q;
        peak_clear = 1'b0;
        peak_en    = 1'b0;
        report     = 1'b0;
        last_step  = 1'b0;
        delay_next = {1'b0, delay_q} + INCR_W;

        if ((state_q != IDLE) && bus.abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        rate_d    = bus.cfg_rate;
                        ov_en_d   = bus.cfg_overlay_en;
                        sel_d     = bus.cfg_sel;
                        delay_d   = SIZE_DELAY'(DELAY_FIRST);
                        overlay_d = 1'b0;
                        cnt_d     = '0;
                        state_d   = SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt_q == SETTLE_CYCLES - 1) begin
                        cnt_d      = '0;
                        peak_clear = 1'b1;
                        state_d    = MEASURE;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                MEASURE: begin
                    peak_en = 1'b1;
                    if (cnt_q == DWELL_CYCLES - 1) begin
                        cnt_d   = '0;
                        state_d = REPORT;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                REPORT: begin
                    report = 1'b1;
                    if (ov_en_q && !overlay_q) begin
                        overlay_d = 1'b1;
                        state_d   = SETTLE;
                    end else if (delay_next > LAST_W) begin
                        last_step = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        delay_d   = delay_next[SIZE_DELAY-1:0];
                        overlay_d = 1'b0;
                        state_d   = SETTLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            delay_q       <= '0;
            overlay_q     <= 1'b0;
            rate_q        <= 1'b0;
            ov_en_q       <= 1'b0;
            sel_q         <= '0;
            sample_q      <= '0;
            res_peak_q    <= '0;
            res_delay_q   <= '0;
            res_overlay_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            delay_q   <= delay_d;
            overlay_q <= overlay_d;
            rate_q    <= rate_d;
            ov_en_q   <= ov_en_d;
            sel_q     <= sel_d;
            sample_q  <= sample_d;
            // Hold the reported values until the next report.
            if (report) begin
                res_peak_q    <= peak;
                res_delay_q   <= delay_q;
                res_overlay_q <= overlay_q;
            end
        end
    end

    filter_test_sequencer_peak_detector u_peak (
        .clk    (clk),
        .reset  (reset),
        .clear  (peak_clear),
        .enable (peak_en),
        .data   (sample_q),
        .peak   (peak)
    );

    assign busy               = (state_q != IDLE);
    assign bus.busy           = busy;
    assign bus.done           = last_step;
    assign bus.result_valid   = report;
    assign bus.result_peak    = report ? peak : res_peak_q;
    assign bus.result_delay   = report ? delay_q : res_delay_q;
    assign bus.result_overlay = report ? overlay_q : res_overlay_q;

    assign test_overlay = busy & overlay_q;
    assign test_rate    = busy & rate_q;
    assign test_delay   = busy ? delay_q : '0;

endmodule

// File: tb/tb_filter_test_sequencer.sv
// Bench for filter_test_sequencer with S=4, D=8, FIRST=2, LAST=6, INCR=2.
// Expected reports are queued before each sweep; a negedge monitor pops one per
// result_valid and compares cycle, delay, overlay, peak and done.
module tb_filter_test_sequencer;
    import filter_test_sequencer_pkg::*;

    localparam int unsigned S     = 4;
    localparam int unsigned D     = 8;
    localparam int unsigned FIRST = 2;
    localparam int unsigned LAST  = 6;
    localparam int unsigned INCR  = 2;
    localparam int unsigned FDW   = NUM_FILTERS * SIZE_FILTER_DATA;

    typedef struct {
        int cyc;
        int delay;
        int overlay;
        int peak;
        int done;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [FDW-1:0]        filter_data = '0;
    logic                  test_overlay;
    logic                  test_rate;
    logic [SIZE_DELAY-1:0] test_delay;

    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   t0 = 0;
    int   data_mode = 0;
    exp_t exp_q[$];

    filter_test_sequencer_if bus ();

    filter_test_sequencer #(
        .SETTLE_CYCLES (S),
        .DWELL_CYCLES  (D),
        .DELAY_FIRST   (FIRST),
        .DELAY_LAST    (LAST),
        .DELAY_INCR    (INCR)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .filter_data  (filter_data),
        .test_overlay (test_overlay),
        .test_rate    (test_rate),
        .test_delay   (test_delay)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (rel cycle %0d)", name, act, exp, cyc - t0);
        end
    endtask

    task automatic wait_rel(input int n);
        while ((cyc - t0) < n) @(negedge clk);
    endtask

    task automatic push(input int c, input int dl, input int ov, input int pk, input int dn);
        exp_t e;
        e.cyc = c; e.delay = dl; e.overlay = ov; e.peak = pk; e.done = dn;
        exp_q.push_back(e);
    endtask

    // Leaves start high for exactly one cycle; cycle 0 is the cycle start is sampled.
    task automatic begin_sweep(input logic ov_en, input logic [2:0] sel, input logic rate);
        @(negedge clk);
        bus.cfg_overlay_en = ov_en;
        bus.cfg_sel        = sel;
        bus.cfg_rate       = rate;
        bus.start          = 1'b1;
        t0                 = cyc;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Mode 0: v1 ramps with the relative cycle, others large.
    // Mode 1: v4 carries the peak pattern, others large.
    function automatic logic [FDW-1:0] gen_data(input int mode, input int c);
        logic [FDW-1:0] v;
        int             v4;
        for (int i = 0; i < NUM_FILTERS; i++) begin
            v[i*SIZE_FILTER_DATA +: SIZE_FILTER_DATA] = (mode == 0) ? 16'sd3000 : 16'sd1000;
        end
        if (mode == 0) begin
            v[SIZE_FILTER_DATA-1:0] = SIZE_FILTER_DATA'(c);
        end else begin
            if (c >= 13)      v4 = -7;
            else if (c == 2)  v4 = 500;
            else if (c == 3)  v4 = 300;
            else if (c == 7)  v4 = 100;
            else if (c == 12) v4 = 400;
            else              v4 = -5;
            v[3*SIZE_FILTER_DATA +: SIZE_FILTER_DATA] = SIZE_FILTER_DATA'(v4);
        end
        return v;
    endfunction

    initial forever begin
        @(negedge clk);
        filter_data = gen_data(data_mode, cyc - t0);
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (bus.result_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_report: got delay %0d overlay %0d at rel cycle %0d, expected none",
                             bus.result_delay, bus.result_overlay, cyc - t0);
                end else begin
                    e = exp_q.pop_front();
                    check("report_cycle", cyc - t0, e.cyc);
                    check("report_delay", int'(bus.result_delay), e.delay);
                    check("report_overlay", int'(bus.result_overlay), e.overlay);
                    check("report_peak", int'($signed(bus.result_peak)), e.peak);
                    check("report_done", int'(bus.done), e.done);
                end
            end else if (bus.done) begin
                check("done_without_report", 1, 0);
            end
        end
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        bus.start          = 1'b0;
        bus.abort          = 1'b0;
        bus.cfg_rate       = 1'b0;
        bus.cfg_overlay_en = 1'b0;
        bus.cfg_sel        = '0;

        // Reset and idle behaviour.
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_valid", int'(bus.result_valid), 0);
        check("rst_peak", int'($signed(bus.result_peak)), 0);
        check("rst_rdelay", int'(bus.result_delay), 0);
        check("rst_roverlay", int'(bus.result_overlay), 0);
        check("rst_toverlay", int'(test_overlay), 0);
        check("rst_trate", int'(test_rate), 0);
        check("rst_tdelay", int'(test_delay), 0);
        repeat (5) @(negedge clk);
        check("idle_busy", int'(bus.busy), 0);
        check("idle_tdelay", int'(test_delay), 0);

        // Plain sweep, ramp on v1, start re-pulsed at cycles 5 and 39.
        data_mode = 0;
        push(13, 2, 0, 11, 0);
        push(26, 4, 0, 24, 0);
        push(39, 6, 0, 37, 1);
        begin_sweep(1'b0, 3'd0, 1'b1);
        wait_rel(1);
        check("b_busy_c1", int'(bus.busy), 1);
        check("b_tdelay_c1", int'(test_delay), 2);
        check("b_toverlay_c1", int'(test_overlay), 0);
        check("b_trate_c1", int'(test_rate), 1);
        wait_rel(5);
        bus.start = 1'b1;
        wait_rel(6);
        bus.start = 1'b0;
        wait_rel(13);
        check("b_tdelay_c13", int'(test_delay), 2);
        wait_rel(14);
        check("b_tdelay_c14", int'(test_delay), 4);
        wait_rel(27);
        check("b_tdelay_c27", int'(test_delay), 6);
        wait_rel(39);
        check("b_busy_c39", int'(bus.busy), 1);
        bus.start = 1'b1;
        wait_rel(40);
        bus.start = 1'b0;
        check("b_busy_c40", int'(bus.busy), 0);
        check("b_tdelay_c40", int'(test_delay), 0);
        check("b_trate_c40", int'(test_rate), 0);
        wait_rel(45);
        check("b_busy_c45", int'(bus.busy), 0);
        check("b_rdelay_hold", int'(bus.result_delay), 6);
        check("b_rpeak_hold", int'($signed(bus.result_peak)), 37);
        check("b_pending", exp_q.size(), 0);

        // Overlay sweep: each delay twice.
        push(13, 2, 0, 11, 0);
        push(26, 2, 1, 24, 0);
        push(39, 4, 0, 37, 0);
        push(52, 4, 1, 50, 0);
        push(65, 6, 0, 63, 0);
        push(78, 6, 1, 76, 1);
        begin_sweep(1'b1, 3'd0, 1'b0);
        wait_rel(14);
        check("c_toverlay_c14", int'(test_overlay), 1);
        check("c_tdelay_c14", int'(test_delay), 2);
        wait_rel(27);
        check("c_toverlay_c27", int'(test_overlay), 0);
        check("c_tdelay_c27", int'(test_delay), 4);
        wait_rel(78);
        check("c_busy_c78", int'(bus.busy), 1);
        wait_rel(79);
        check("c_busy_c79", int'(bus.busy), 0);
        check("c_pending", exp_q.size(), 0);

        // Peak selection on v4, settle spike and window-edge spikes excluded.
        data_mode = 1;
        push(13, 2, 0, 100, 0);
        push(26, 4, 0, -7, 0);
        push(39, 6, 0, -7, 1);
        begin_sweep(1'b0, 3'd3, 1'b0);
        wait_rel(42);
        check("d_pending", exp_q.size(), 0);

        // Select 7 falls back to v1.
        data_mode = 0;
        push(13, 2, 0, 11, 0);
        push(26, 4, 0, 24, 0);
        push(39, 6, 0, 37, 1);
        begin_sweep(1'b0, 3'd7, 1'b0);
        wait_rel(42);
        check("e_pending", exp_q.size(), 0);

        // Abort during step 2 MEASURE.
        push(13, 2, 0, 11, 0);
        begin_sweep(1'b0, 3'd0, 1'b1);
        wait_rel(20);
        check("f_busy_c20", int'(bus.busy), 1);
        bus.abort = 1'b1;
        wait_rel(21);
        bus.abort = 1'b0;
        check("f_busy_c21", int'(bus.busy), 0);
        check("f_tdelay_c21", int'(test_delay), 0);
        check("f_toverlay_c21", int'(test_overlay), 0);
        check("f_trate_c21", int'(test_rate), 0);
        wait_rel(45);
        check("f_pending", exp_q.size(), 0);

        // start together with abort while idle.
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("g_busy", int'(bus.busy), 0);
        check("g_tdelay", int'(test_delay), 0);
        repeat (3) @(negedge clk);
        check("g_busy_later", int'(bus.busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
